ifm_buf_mgr: RTL and testbench
==============================

Name: ifm_buf_mgr

Overview:
IFM line-buffer manager that sits directly upstream of the CNN controller. It services the controller's row-load requests (o_ifm_buf_req_load / o_ifm_buf_req_row) by fetching one full input-feature-map row from external memory into one of IFM_BUF_CNT on-chip line buffers. It signals completion through the controller's q_ifm_buf_done input and provides a 1-cycle-latency read port to the PE.

Parameters:
W_SIZE, 12, width of row/col/width/height values
W_CHANNEL, 12, width of the tiled channel count
IFM_BUF_CNT, 4, number of line buffers; a power of two
W_IFM_BUF, 2, log2(IFM_BUF_CNT)
W_BUF_ADDR, 10, word-address width per line buffer; depth BUF_DEPTH = 2**W_BUF_ADDR
W_DATA, 32, one tile word (4 ch x 8 bit)
W_ADDR, 32, external byte-address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
q_width  in  W_SIZE  IFM width in columns
q_channel  in  W_CHANNEL  tiled channel count
q_base_addr  in  W_ADDR  byte address of row 0, word 0
q_req_load  in  1  load-request pulse (from the controller's o_ifm_buf_req_load)
q_req_row  in  W_SIZE  row to load
o_req_done  out  1  1-cycle pulse when the load completes (to the controller's q_ifm_buf_done)
o_busy  out  1  high while a load is in progress
o_err  out  1  sticky oversize-row error
o_mem_arvalid  out  1  read-address valid
i_mem_arready  in  1  read-address accept
o_mem_araddr  out  W_ADDR  read byte address
i_mem_rvalid  in  1  read-data valid; in order; never back-pressured
i_mem_rdata  in  W_DATA  read data
q_rd_en  in  1  PE read strobe
q_rd_row  in  W_SIZE  PE row
q_rd_col  in  W_SIZE  PE column
q_rd_chn  in  W_CHANNEL  PE channel
o_rd_data  out  W_DATA  read data
o_rd_valid  out  1  read data valid

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. All counters go to 0. Buffer contents are undefined.
- Sizes: beats = q_width*q_channel, computed at full product width. Row offset = q_req_row*beats. Both are latched at request acceptance.
- Address: araddr = q_base_addr + (row_off + issue_cnt)*4. This gives word order col fastest, then chn, which matches the controller's traversal order.
- Buffer slot: sel = q_req_row[W_IFM_BUF-1:0]. Word index within the slot = chn*q_width + col, for both writes and reads.
- FSM IDLE:
  - q_req_load with beats <= BUF_DEPTH: latch the request, go to LOAD. The first o_mem_arvalid is asserted the next cycle.
  - q_req_load with beats > BUF_DEPTH or beats == 0: set o_err, go to DONE. No memory traffic is issued.
- FSM LOAD:
  - o_busy = 1.
  - o_mem_arvalid stays high while issue_cnt < beats. issue_cnt increments on arvalid & arready. araddr holds stable while arvalid is high and not yet accepted.
  - Each i_mem_rvalid writes rdata to buffer[sel][recv_cnt] in the same cycle, then recv_cnt increments.
  - When recv_cnt reaches beats-1 and rvalid is high, go to DONE.
- FSM DONE: o_req_done = 1 for exactly one cycle, then go to IDLE. o_busy = 0 in DONE.
- Completion latency: o_req_done is asserted exactly one cycle after the final rvalid beat.
- q_req_load outside IDLE is ignored and does not set o_err.
- i_mem_rvalid in IDLE or DONE (for example, stale after reset) is dropped with no write.
- PE read path:
  - q_rd_en at cycle T gives o_rd_data and o_rd_valid = 1 at T+1.
  - o_rd_valid is 0 when q_rd_en was 0. o_rd_data holds its previous value when not reading.
  - Reads are always allowed, including during LOAD.
  - Same-cycle read and write to the same word returns the old contents (read-first).
- Wrap-around: row r and row r+IFM_BUF_CNT share a slot. The newer load overwrites the slot. The controller guarantees a slot is retired before it is reused; this block does not check.
- Async reset mid-LOAD aborts the load. No o_req_done is issued.
- o_err clears only on reset.

Optional Feature:
IFM_BUF_PERF_EN:
- Defined: adds output o_perf_load_cycles [31:0]. It counts every cycle spent in LOAD, saturates at 2^32-1, and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Basic load: width=4, channel=2, base=0x1000, req row 3; memory returns data = address, arready=1, rvalid 2 cycles later -> araddr sequence 0x1060..0x107C; o_req_done is high exactly one cycle after the 8th rvalid; reads (row3,col1,chn1) give 0x1074 one cycle after q_rd_en.
2. Back-pressure: arready toggles 1010..., rvalid gaps are random -> araddr is held while not accepted, no beat is lost or duplicated, and exactly 8 writes occur.
3. Wrap-around: load row 1, then row 5 (width 2, ch 1) -> slot 1 holds row-5 data; slot 0 is untouched.
4. Oversize: width=64, channel=32 (2048 > 1024) -> no arvalid, o_err=1, o_req_done pulses 2 cycles after the request.
5. Ignored and stale traffic: a second q_req_load during LOAD is ignored; assert rstn low mid-load, then inject rvalid -> no o_req_done, no write, FSM stays in IDLE.
6. With IFM_BUF_PERF_EN: row load of 8 beats, arready=1, 2-cycle read latency -> o_perf_load_cycles equals the measured number of LOAD cycles (10).

Source files
------------

// File: rtl/ifm_buf_mgr.sv
// ifm_buf_mgr: IFM line-buffer manager feeding the CNN controller.
// Fetches one input-feature-map row from external memory into one of
// IFM_BUF_CNT line buffers and serves the PE through a one-cycle read port.
// Optional build macro IFM_BUF_PERF_EN adds o_perf_load_cycles, a saturating
// count of cycles spent loading.
module ifm_buf_mgr #(
  parameter int W_SIZE      = 12,
  parameter int W_CHANNEL   = 12,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_BUF_ADDR  = 10,
  parameter int W_DATA      = 32,
  parameter int W_ADDR      = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W_SIZE-1:0]    q_width,
  input  logic [W_CHANNEL-1:0] q_channel,
  input  logic [W_ADDR-1:0]    q_base_addr,
  input  logic                 q_req_load,
  input  logic [W_SIZE-1:0]    q_req_row,
  output logic                 o_req_done,
  output logic                 o_busy,
  output logic                 o_err,
  output logic                 o_mem_arvalid,
  input  logic                 i_mem_arready,
  output logic [W_ADDR-1:0]    o_mem_araddr,
  input  logic                 i_mem_rvalid,
  input  logic [W_DATA-1:0]    i_mem_rdata,
  input  logic                 q_rd_en,
  input  logic [W_SIZE-1:0]    q_rd_row,
  input  logic [W_SIZE-1:0]    q_rd_col,
  input  logic [W_CHANNEL-1:0] q_rd_chn,
  output logic [W_DATA-1:0]    o_rd_data,
  output logic                 o_rd_valid
`ifdef IFM_BUF_PERF_EN
  ,
  output logic [31:0]          o_perf_load_cycles
`endif
);

  localparam int BUF_DEPTH = 1 << W_BUF_ADDR;
  localparam int W_BEATS   = W_SIZE + W_CHANNEL;
  localparam int W_OFF     = W_SIZE + W_BEATS;
  localparam int W_MIDX    = W_IFM_BUF + W_BUF_ADDR;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;

  logic [W_BEATS-1:0]   beats;
  logic [W_BEATS-1:0]   issue_cnt;
  logic [W_BEATS-1:0]   recv_cnt;
  logic [W_IFM_BUF-1:0] sel;

  logic [W_BEATS-1:0] req_beats;
  logic [W_OFF-1:0]   req_row_off;
  logic [W_ADDR-1:0]  req_araddr;
  logic               req_bad;

  logic [W_BEATS-1:0] rd_word;
  logic [W_MIDX-1:0]  rd_idx;
  logic [W_MIDX-1:0]  wr_idx;
  logic               wr_en;

  logic [W_DATA-1:0] buf_mem [IFM_BUF_CNT*BUF_DEPTH];

  // Row geometry of an incoming request: beat count, starting byte address,
  // and whether the row fits in one line buffer.
  always_comb begin
    req_beats   = W_BEATS'(q_width) * W_BEATS'(q_channel);
    req_row_off = W_OFF'(q_req_row) * W_OFF'(req_beats);
    req_araddr  = q_base_addr + W_ADDR'({req_row_off, 2'b00});
    req_bad     = (req_beats == '0) || (req_beats > W_BEATS'(BUF_DEPTH));
  end

  // Word order inside a slot is col fastest, then chn, so the receive count
  // of a load is directly the write word index.
  assign rd_word = W_BEATS'(q_rd_chn) * W_BEATS'(q_width) + W_BEATS'(q_rd_col);
  assign rd_idx  = {q_rd_row[W_IFM_BUF-1:0], rd_word[W_BUF_ADDR-1:0]};
  assign wr_idx  = {sel, recv_cnt[W_BUF_ADDR-1:0]};
  assign wr_en   = (state == LOAD) && i_mem_rvalid;

  logic unused_bits;
  assign unused_bits = ^{q_rd_row[W_SIZE-1:W_IFM_BUF], rd_word[W_BEATS-1:W_BUF_ADDR]};

  // Load sequencer: accepts a request in IDLE, issues read addresses and
  // counts returning beats in LOAD, and pulses completion from DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      beats         <= '0;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      sel           <= '0;
      o_req_done    <= 1'b0;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
      o_mem_arvalid <= 1'b0;
      o_mem_araddr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q_req_load) begin
            if (req_bad) begin
              o_err <= 1'b1;
              state <= DONE;
            end else begin
              beats         <= req_beats;
              sel           <= q_req_row[W_IFM_BUF-1:0];
              issue_cnt     <= '0;
              recv_cnt      <= '0;
              o_mem_araddr  <= req_araddr;
              o_mem_arvalid <= 1'b1;
              o_busy        <= 1'b1;
              state         <= LOAD;
            end
          end
        end
        LOAD: begin
          if (o_mem_arvalid && i_mem_arready) begin
            issue_cnt    <= issue_cnt + W_BEATS'(1);
            o_mem_araddr <= o_mem_araddr + W_ADDR'(4);
            if (issue_cnt + W_BEATS'(1) >= beats) begin
              o_mem_arvalid <= 1'b0;
            end
          end
          if (i_mem_rvalid) begin
            recv_cnt <= recv_cnt + W_BEATS'(1);
            if (recv_cnt == beats - W_BEATS'(1)) begin
              o_req_done    <= 1'b1;
              o_busy        <= 1'b0;
              o_mem_arvalid <= 1'b0;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          // A completed load enters DONE with the pulse already raised; a
          // rejected request raises it here, one cycle later.
          if (o_req_done) begin
            o_req_done <= 1'b0;
            state      <= IDLE;
          end else begin
            o_req_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line-buffer storage; only beats that arrive while loading are written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_idx] <= i_mem_rdata;
    end
  end

  // PE read port: one-cycle latency, read-first against a same-cycle write,
  // data held between reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= q_rd_en;
      if (q_rd_en) begin
        o_rd_data <= buf_mem[rd_idx];
      end
    end
  end

`ifdef IFM_BUF_PERF_EN
  // Saturating count of every cycle the sequencer spends in LOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_perf_load_cycles <= '0;
    end else if ((state == LOAD) && (o_perf_load_cycles != '1)) begin
      o_perf_load_cycles <= o_perf_load_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifm_buf_mgr.sv
// tb_ifm_buf_mgr: randomized scoreboard bench for ifm_buf_mgr with a
// behavioural memory responder and a word-level model of the line buffers.
module tb_ifm_buf_mgr;

  localparam int W_SIZE    = 12;
  localparam int W_CHANNEL = 12;
  localparam int W_ADDR    = 32;
  localparam int W_DATA    = 32;

  logic                 clk;
  logic                 rstn;
  logic [W_SIZE-1:0]    q_width;
  logic [W_CHANNEL-1:0] q_channel;
  logic [W_ADDR-1:0]    q_base_addr;
  logic                 q_req_load;
  logic [W_SIZE-1:0]    q_req_row;
  logic                 o_req_done;
  logic                 o_busy;
  logic                 o_err;
  logic                 o_mem_arvalid;
  logic                 i_mem_arready;
  logic [W_ADDR-1:0]    o_mem_araddr;
  logic                 i_mem_rvalid;
  logic [W_DATA-1:0]    i_mem_rdata;
  logic                 q_rd_en;
  logic [W_SIZE-1:0]    q_rd_row;
  logic [W_SIZE-1:0]    q_rd_col;
  logic [W_CHANNEL-1:0] q_rd_chn;
  logic [W_DATA-1:0]    o_rd_data;
  logic                 o_rd_valid;
`ifdef IFM_BUF_PERF_EN
  logic [31:0]          o_perf_load_cycles;
`endif

  ifm_buf_mgr dut (
    .clk           (clk),
    .rstn          (rstn),
    .q_width       (q_width),
    .q_channel     (q_channel),
    .q_base_addr   (q_base_addr),
    .q_req_load    (q_req_load),
    .q_req_row     (q_req_row),
    .o_req_done    (o_req_done),
    .o_busy        (o_busy),
    .o_err         (o_err),
    .o_mem_arvalid (o_mem_arvalid),
    .i_mem_arready (i_mem_arready),
    .o_mem_araddr  (o_mem_araddr),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .q_rd_en       (q_rd_en),
    .q_rd_row      (q_rd_row),
    .q_rd_col      (q_rd_col),
    .q_rd_chn      (q_rd_chn),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid)
`ifdef IFM_BUF_PERF_EN
    ,
    .o_perf_load_cycles (o_perf_load_cycles)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          junk;
  } beat_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_seen = 0;

  int cur_w, cur_c;
  logic [31:0] cur_base;
  int ar_mode, lat_min, lat_max, gap_pct;
  int beats_left;
  int last_beat_cyc;
  bit stale_after;
  bit ar_toggle;

  beat_t       pend[$];
  logic [31:0] ar_exp[$];
  int          done_exp[$];
  logic [31:0] rd_exp[$];

  logic [31:0] model_mem [4][1024];
  bit          known     [4][1024];
  int          slot_max  [4];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: the value seen during a clock period is that period's number.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Upper bound on run time.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // External memory: random arready, in-order read data equal to the address
  // after a random latency, optional gaps between beats.
  initial begin : responder
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend.delete();
        i_mem_rvalid  = 1'b0;
        i_mem_arready = 1'b0;
      end else begin
        i_mem_rvalid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(0, 99)) >= gap_pct) begin
          b = pend.pop_front();
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = b.data;
          if (!b.junk && beats_left > 0) begin
            beats_left--;
            if (beats_left == 0) begin
              done_exp.push_back(cyc + 1);
              last_beat_cyc = cyc;
              if (stale_after) begin
                pend.push_back('{due: cyc + 1, data: 32'hDEAD_0001, junk: 1'b1});
                pend.push_back('{due: cyc + 2, data: 32'hDEAD_0002, junk: 1'b1});
              end
            end
          end
        end
        case (ar_mode)
          0: i_mem_arready = 1'b1;
          1: begin
            ar_toggle     = !ar_toggle;
            i_mem_arready = ar_toggle;
          end
          default: i_mem_arready = ($urandom_range(0, 1) == 1);
        endcase
        if (o_mem_arvalid && i_mem_arready)
          pend.push_back('{due: cyc + int'($urandom_range(lat_min, lat_max)), data: o_mem_araddr, junk: 1'b0});
      end
    end
  end

  // Monitor: compares every address handshake, completion pulse and read
  // response against the scoreboard queues.
  initial begin : monitor
    bit          hold_pend;
    logic [31:0] hold_addr;
    hold_pend = 1'b0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        hold_pend = 1'b0;
        continue;
      end
      if (hold_pend) begin
        checkOutput("ar_hold_valid", 32'(o_mem_arvalid), 32'd1);
        checkOutput("ar_hold_addr", o_mem_araddr, hold_addr);
      end
      hold_pend = o_mem_arvalid && !i_mem_arready;
      hold_addr = o_mem_araddr;
      if (o_mem_arvalid && i_mem_arready) begin
        if (ar_exp.size() == 0) checkOutput("ar_unexpected", 32'(o_mem_arvalid), 32'd0);
        else checkOutput("araddr", o_mem_araddr, ar_exp.pop_front());
      end
      if (o_req_done) begin
        done_seen++;
        if (done_exp.size() == 0) checkOutput("done_unexpected", 32'(o_req_done), 32'd0);
        else checkOutput("done_cycle", 32'(cyc), 32'(done_exp.pop_front()));
      end
      if (o_rd_valid) begin
        if (rd_exp.size() == 0) checkOutput("rd_unexpected", 32'(o_rd_valid), 32'd0);
        else checkOutput("rd_data", o_rd_data, rd_exp.pop_front());
      end
    end
  end

  task automatic clearModel();
    for (int s = 0; s < 4; s++) begin
      slot_max[s] = 0;
      for (int i = 0; i < 1024; i++) known[s][i] = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    pend.delete();
    ar_exp.delete();
    done_exp.delete();
    beats_left  = 0;
    stale_after = 1'b0;
    clearModel();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic waitDone(input int budget);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_seen == start) checkOutput("done_timeout", 32'(done_seen), 32'(start + 1));
    @(negedge clk);
  endtask

  // Issue one PE read of model word idx in a slot, using any row aliasing it.
  task automatic applyStimulus(input int slot, input int idx);
    @(negedge clk);
    q_rd_en  = 1'b1;
    q_rd_row = W_SIZE'(slot + 4 * int'($urandom_range(0, 7)));
    q_rd_chn = W_CHANNEL'(idx / cur_w);
    q_rd_col = W_SIZE'(idx % cur_w);
    rd_exp.push_back(model_mem[slot][idx]);
  endtask

  task automatic endReads();
    @(negedge clk);
    q_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rd_drain", 32'(rd_exp.size()), 32'd0);
  endtask

  task automatic readRandom(input int n);
    for (int k = 0; k < n; k++) begin
      int slot, idx;
      bit found;
      found = 1'b0;
      for (int t = 0; t < 100 && !found; t++) begin
        slot = int'($urandom_range(0, 3));
        if (slot_max[slot] > 0) begin
          idx   = int'($urandom_range(0, slot_max[slot] - 1));
          found = known[slot][idx];
        end
      end
      if (found) applyStimulus(slot, idx);
    end
    endReads();
  endtask

  // Request one row load; the model derives every address, the data of each
  // buffer word and the completion time from the row geometry.
  task automatic loadRow(input int row, input bit second);
    int beats, req_cyc, slot;
    logic [31:0] perf_start;
    beats = cur_w * cur_c;
    slot  = row % 4;
    perf_start = '0;
    @(negedge clk);
`ifdef IFM_BUF_PERF_EN
    perf_start = o_perf_load_cycles;
`endif
    q_width     = W_SIZE'(cur_w);
    q_channel   = W_CHANNEL'(cur_c);
    q_base_addr = cur_base;
    q_req_row   = W_SIZE'(row);
    if (beats == 0 || beats > 1024) begin
      done_exp.push_back(cyc + 2);
      q_req_load = 1'b1;
      @(negedge clk);
      q_req_load = 1'b0;
      #1 checkOutput("err_busy", 32'(o_busy), 32'd0);
      waitDone(20);
      checkOutput("err_flag", 32'(o_err), 32'd1);
      checkOutput("err_no_ar", 32'(ar_exp.size()), 32'd0);
    end else begin
      for (int i = 0; i < beats; i++) begin
        logic [31:0] a;
        a = cur_base + 32'((row * beats + i) * 4);
        ar_exp.push_back(a);
        model_mem[slot][i] = a;
        known[slot][i]     = 1'b1;
      end
      if (beats > slot_max[slot]) slot_max[slot] = beats;
      beats_left = beats;
      req_cyc    = cyc;
      q_req_load = 1'b1;
      @(negedge clk);
      q_req_load = 1'b0;
      #1 checkOutput("busy", 32'(o_busy), 32'd1);
      if (second) begin
        @(negedge clk);
        q_req_row  = W_SIZE'(row + 1);
        q_req_load = 1'b1;
        @(negedge clk);
        q_req_load = 1'b0;
      end
      waitDone(3000);
      checkOutput("ar_drain", 32'(ar_exp.size()), 32'd0);
      checkOutput("no_err", 32'(o_err), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("idle_busy", 32'(o_busy), 32'd0);
`ifdef IFM_BUF_PERF_EN
      checkOutput("perf_cycles", o_perf_load_cycles - perf_start, 32'(last_beat_cyc - req_cyc));
`endif
    end
  endtask

  task automatic setMem(input int mode, input int lmin, input int lmax, input int gap);
    ar_mode = mode;
    lat_min = lmin;
    lat_max = lmax;
    gap_pct = gap;
  endtask

  initial begin : main
    rstn = 1'b0;
    q_width = '0; q_channel = '0; q_base_addr = '0;
    q_req_load = 1'b0; q_req_row = '0;
    i_mem_arready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    q_rd_en = 1'b0; q_rd_row = '0; q_rd_col = '0; q_rd_chn = '0;
    cur_w = 4; cur_c = 2; cur_base = 32'h1000;
    beats_left = 0; stale_after = 1'b0; ar_toggle = 1'b0; last_beat_cyc = 0;
    setMem(0, 2, 2, 0);
    clearModel();

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_done", 32'(o_req_done), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_err", 32'(o_err), 32'd0);
    checkOutput("rst_arvalid", 32'(o_mem_arvalid), 32'd0);
    checkOutput("rst_araddr", o_mem_araddr, 32'd0);
    checkOutput("rst_rd_data", o_rd_data, 32'd0);
    checkOutput("rst_rd_valid", 32'(o_rd_valid), 32'd0);
`ifdef IFM_BUF_PERF_EN
    checkOutput("rst_perf", o_perf_load_cycles, 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // Basic load of row 3, then the directed read of row 3, col 1, chn 1.
    $display("[TB] basic load");
    loadRow(3, 1'b0);
    @(negedge clk);
    q_rd_en = 1'b1; q_rd_row = 12'd3; q_rd_col = 12'd1; q_rd_chn = 12'd1;
    rd_exp.push_back(32'h0000_1074);
    endReads();
    readRandom(8);

    // Toggling arready and random gaps between read beats.
    $display("[TB] back-pressure");
    setMem(1, 1, 4, 30);
    loadRow(6, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(2, i);
    endReads();

    // Slot sharing between rows 1 and 5.
    $display("[TB] wrap-around");
    cur_w = 2; cur_c = 1; cur_base = 32'h2000;
    setMem(2, 1, 3, 10);
    loadRow(0, 1'b0);
    loadRow(1, 1'b0);
    loadRow(5, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(0, i);
    for (int i = 0; i < 2; i++) applyStimulus(1, i);
    endReads();

    // Randomized geometries, rows, bases and memory behaviour.
    $display("[TB] random loads");
    for (int n = 0; n < 12; n++) begin
      cur_w    = int'($urandom_range(1, 8));
      cur_c    = int'($urandom_range(1, 4));
      cur_base = $urandom & 32'hFFFF_FFFC;
      setMem(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), int'($urandom_range(3, 5)),
             int'($urandom_range(0, 40)));
      loadRow(int'($urandom_range(0, 40)), 1'b0);
      readRandom(6);
    end

    // A second request during LOAD must be ignored.
    $display("[TB] ignored request");
    cur_w = 4; cur_c = 2; cur_base = 32'h4000;
    setMem(0, 2, 2, 0);
    loadRow(7, 1'b1);
    readRandom(4);

    // Beats arriving in DONE and IDLE must not be written.
    $display("[TB] stale beats after completion");
    cur_c = 4;
    loadRow(0, 1'b0);
    cur_c = 2;
    stale_after = 1'b1;
    loadRow(4, 1'b0);
    stale_after = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) applyStimulus(0, i);
    endReads();

    // Reset in the middle of a load, then stale beats after reset.
    $display("[TB] reset mid-load");
    setMem(0, 6, 8, 0);
    @(negedge clk);
    q_req_row = 12'd2;
    for (int i = 0; i < 8; i++) ar_exp.push_back(cur_base + 32'((2 * 8 + i) * 4));
    beats_left = 8;
    q_req_load = 1'b1;
    @(negedge clk);
    q_req_load = 1'b0;
    repeat (4) @(negedge clk);
    doReset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) pend.push_back('{due: cyc + i, data: 32'hBAD0_0000 + 32'(i), junk: 1'b1});
    repeat (6) @(negedge clk);
    #1;
    checkOutput("stale_busy", 32'(o_busy), 32'd0);
    checkOutput("stale_arvalid", 32'(o_mem_arvalid), 32'd0);
    checkOutput("stale_err", 32'(o_err), 32'd0);
    setMem(2, 1, 4, 20);
    loadRow(2, 1'b0);
    readRandom(6);

    // Rejected geometries: oversize row and zero-width row.
    $display("[TB] oversize");
    cur_w = 64; cur_c = 32;
    loadRow(9, 1'b0);
    cur_w = 0; cur_c = 3;
    loadRow(1, 1'b0);
    doReset();
    #1 checkOutput("err_cleared", 32'(o_err), 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
